// File: rtl/alu_op_responder.sv
// alu_op_responder
// ----------------
// Sequential WIDTH-bit ALU responder. It accepts one operation at a time
// on a valid/ready request channel and returns a registered result on a
// valid/ready response channel. Logic, add and sub results are registered
// on the accept edge. MUL runs an iterative shift-add over WIDTH cycles,
// then spends one more cycle registering the product.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   req_valid  - request present
//   req_ready  - responder can accept a request (IDLE and not in reset)
//   req_op     - 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL,
//                110/111 reserved
//   req_a      - operand A
//   req_b      - operand B
//   rsp_valid  - response present
//   rsp_ready  - consumer accepts the response
//   rsp_f      - result (low half of the product for MUL)
//   rsp_hi     - high half of the product for MUL, 0 otherwise
//   rsp_carry  - carry out (ADD), no-borrow (SUB), hi != 0 (MUL), else 0
//   rsp_zero   - result is zero (whole product for MUL)
//   rsp_err    - reserved opcode was received
module alu_op_responder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;

    logic               accept;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_f;
    logic               alu_carry;
    logic               alu_err;

    // Ready is gated by reset, so a requester never sees ready while the
    // block is being held in reset.
    assign req_ready = (state == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // Single-cycle result path. The extra top bit of sum/diff is the carry
    // out of the add, or the borrow of the subtract (borrow=1 means A<B).
    // Reserved opcodes fall through to f=0 with the error flag raised.
    always_comb begin
        sum       = {1'b0, req_a} + {1'b0, req_b};
        diff      = {1'b0, req_a} - {1'b0, req_b};
        alu_f     = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (req_op)
            OP_AND: alu_f = req_a & req_b;
            OP_OR:  alu_f = req_a | req_b;
            OP_XOR: alu_f = req_a ^ req_b;
            OP_ADD: begin
                alu_f     = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OP_SUB: begin
                alu_f     = diff[WIDTH-1:0];
                alu_carry = !diff[WIDTH];
            end
            OP_MUL: alu_f = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Control and datapath registers. MUL iterates while the counter is
    // non-zero; the cycle after it reaches zero registers the product, so
    // rsp_valid rises WIDTH+1 cycles after the accept edge. The rsp_*
    // registers keep their last value in IDLE; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_f     <= '0;
            rsp_hi    <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_op == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, req_a};
                            mplier <= req_b;
                            acc    <= '0;
                            count  <= CNT_W'(WIDTH);
                            state  <= ST_MUL;
                        end else begin
                            rsp_f     <= alu_f;
                            rsp_hi    <= '0;
                            rsp_carry <= alu_carry;
                            rsp_zero  <= (alu_f == '0);
                            rsp_err   <= alu_err;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_MUL: begin
                    if (count != '0) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count - CNT_W'(1);
                    end else begin
                        rsp_f     <= acc[WIDTH-1:0];
                        rsp_hi    <= acc[2*WIDTH-1:WIDTH];
                        rsp_carry <= (acc[2*WIDTH-1:WIDTH] != '0);
                        rsp_zero  <= (acc == '0);
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_responder.sv
// tb_alu_op_responder
// -------------------
// Directed testbench for alu_op_responder (WIDTH=8). Each scenario task
// drives its own stimulus and compares outputs against hand-computed
// expected values. Outputs are sampled 1ns after the rising edge.
module tb_alu_op_responder;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_f;
    logic [7:0] rsp_hi;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_err;

    int vectors;
    int miscompares;

    alu_op_responder #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_hi    (rsp_hi),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vector tables: op, A, B, expected f, carry, zero.
    logic [2:0] lg_op [0:4] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b010};
    logic [7:0] lg_a  [0:4] = '{8'hFF, 8'h87, 8'hA0, 8'h3C, 8'hFF};
    logic [7:0] lg_b  [0:4] = '{8'h7B, 8'h0A, 8'h05, 8'h0F, 8'hFF};
    logic [7:0] lg_f  [0:4] = '{8'h7B, 8'h02, 8'hA5, 8'h33, 8'h00};
    logic       lg_z  [0:4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic [2:0] ar_op [0:3] = '{3'b011, 3'b100, 3'b100, 3'b011};
    logic [7:0] ar_a  [0:3] = '{8'd200, 8'd5, 8'd10, 8'hFF};
    logic [7:0] ar_b  [0:3] = '{8'd100, 8'd10, 8'd10, 8'h01};
    logic [7:0] ar_f  [0:3] = '{8'h2C, 8'hFB, 8'h00, 8'h00};
    logic       ar_c  [0:3] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       ar_z  [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};

    logic [7:0] mu_a  [0:2] = '{8'd135, 8'h00, 8'hFF};
    logic [7:0] mu_b  [0:2] = '{8'd10, 8'h77, 8'hFF};
    logic [7:0] mu_hi [0:2] = '{8'h05, 8'h00, 8'hFE};
    logic [7:0] mu_f  [0:2] = '{8'h46, 8'h00, 8'h01};
    logic       mu_c  [0:2] = '{1'b1, 1'b0, 1'b1};
    logic       mu_z  [0:2] = '{1'b0, 1'b1, 1'b0};

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; the DUT must be idle beforehand.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
    endtask

    // Complete the response handshake in one edge.
    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        vectors++;
        if ({rsp_valid, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err} !== 20'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {rsp_valid, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err});
        end
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready_low: got %b expected 0", req_ready);
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready);
        end
        tick();
    endtask

    task automatic test_logic();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (req_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL logic_ready[%0d]: got %b expected 1", i, req_ready);
            end
            issue(lg_op[i], lg_a[i], lg_b[i]);
            vectors++;
            if (rsp_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL logic_latency[%0d]: rsp_valid got %b expected 1", i, rsp_valid);
            end
            vectors++;
            if ({rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err} !== {lg_f[i], 8'h00, 1'b0, lg_z[i], 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL logic_result[%0d]: got f=%h hi=%h c=%b z=%b e=%b expected f=%h hi=00 c=0 z=%b e=0",
                         i, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err, lg_f[i], lg_z[i]);
            end
            consume();
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL logic_drop[%0d]: rsp_valid got %b expected 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_arith();
        for (int i = 0; i < 4; i++) begin
            issue(ar_op[i], ar_a[i], ar_b[i]);
            vectors++;
            if (rsp_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL arith_latency[%0d]: rsp_valid got %b expected 1", i, rsp_valid);
            end
            vectors++;
            if ({rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err} !== {ar_f[i], 8'h00, ar_c[i], ar_z[i], 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL arith_result[%0d]: got f=%h hi=%h c=%b z=%b e=%b expected f=%h hi=00 c=%b z=%b e=0",
                         i, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err, ar_f[i], ar_c[i], ar_z[i]);
            end
            consume();
        end
    endtask

    task automatic test_mul();
        for (int i = 0; i < 3; i++) begin
            issue(3'b101, mu_a[i], mu_b[i]);
            // Response must stay low for edges 0..8 after the accept edge.
            for (int k = 0; k < 9; k++) begin
                vectors++;
                if ({rsp_valid, req_ready} !== 2'b00) begin
                    miscompares++;
                    $display("[TB] FAIL mul_busy[%0d] cycle %0d: valid/ready got %b expected 00",
                             i, k, {rsp_valid, req_ready});
                end
                tick();
            end
            vectors++;
            if (rsp_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL mul_latency[%0d]: rsp_valid got %b expected 1", i, rsp_valid);
            end
            vectors++;
            if ({rsp_hi, rsp_f, rsp_carry, rsp_zero, rsp_err} !== {mu_hi[i], mu_f[i], mu_c[i], mu_z[i], 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL mul_result[%0d]: got hi=%h f=%h c=%b z=%b e=%b expected hi=%h f=%h c=%b z=%b e=0",
                         i, rsp_hi, rsp_f, rsp_carry, rsp_zero, rsp_err, mu_hi[i], mu_f[i], mu_c[i], mu_z[i]);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        issue(3'b011, 8'd200, 8'd100);
        // Hold off the consumer while a competing request sits on the bus.
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_a     = 8'h0F;
        req_b     = 8'hF0;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({rsp_valid, req_ready, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err} !==
                {1'b1, 1'b0, 8'h2C, 8'h00, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL hold[%0d]: got v=%b r=%b f=%h hi=%h c=%b z=%b e=%b expected v=1 r=0 f=2c hi=00 c=1 z=0 e=0",
                         k, rsp_valid, req_ready, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL handshake_idle: valid/ready got %b expected 01", {rsp_valid, req_ready});
        end
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_f, rsp_carry, rsp_zero} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL b2b_result: got v=%b f=%h c=%b z=%b expected v=1 f=00 c=0 z=1",
                     rsp_valid, rsp_f, rsp_carry, rsp_zero);
        end
        consume();
    endtask

    task automatic test_reset_mid_mul();
        issue(3'b011, 8'd200, 8'd100);
        consume();
        issue(3'b101, 8'd135, 8'd10);
        tick();
        tick();
        tick();
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err} !== 21'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got r=%b v=%b f=%h hi=%h c=%b z=%b e=%b expected all 0",
                     req_ready, rsp_valid, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err);
        end
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: ready/valid got %b expected 10", {req_ready, rsp_valid});
        end
        tick();
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stale_mul[%0d]: rsp_valid got %b expected 0", k, rsp_valid);
            end
            tick();
        end
        issue(3'b000, 8'h01, 8'h01);
        vectors++;
        if ({rsp_valid, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err} !== {1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL after_reset_and: got v=%b f=%h hi=%h c=%b z=%b e=%b expected v=1 f=01 hi=00 c=0 z=0 e=0",
                     rsp_valid, rsp_f, rsp_hi, rsp_carry, rsp_zero, rsp_err);
        end
        consume();
    endtask

    task automatic test_reserved();
        issue(3'b110, 8'h12, 8'h34);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_f, rsp_hi, rsp_carry, rsp_zero} !== {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reserved_110: got v=%b e=%b f=%h hi=%h c=%b z=%b expected v=1 e=1 f=00 hi=00 c=0 z=1",
                     rsp_valid, rsp_err, rsp_f, rsp_hi, rsp_carry, rsp_zero);
        end
        consume();
        issue(3'b111, 8'hFF, 8'hFF);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_f, rsp_zero} !== {1'b1, 1'b1, 8'h00, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reserved_111: got v=%b e=%b f=%h z=%b expected v=1 e=1 f=00 z=1",
                     rsp_valid, rsp_err, rsp_f, rsp_zero);
        end
        consume();
        issue(3'b001, 8'h01, 8'h02);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_f} !== {1'b1, 1'b0, 8'h03}) begin
            miscompares++;
            $display("[TB] FAIL after_reserved: got v=%b e=%b f=%h expected v=1 e=0 f=03",
                     rsp_valid, rsp_err, rsp_f);
        end
        consume();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_op      = 3'b000;
        req_a       = 8'h00;
        req_b       = 8'h00;
        rsp_ready   = 1'b0;

        test_reset();
        test_logic();
        test_arith();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_reserved();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
